sample_fir: RTL and testbench
=============================

SAMPLE_FIR -- requirements
Module: sample_fir

Interface
REQ-001 SHALL have parameters: N_TAPS default 4, tap count (2..8); COEF_W default 8, signed coefficient width; FRAC_BITS default 6, coefficient fraction bits (64 = unity gain).
REQ-002 SHALL have ports (name, direction, width, meaning):
  qzt_clk  in  1  50 MHz system clock; all state on rising edge.
  rst_n  in  1  asynchronous active-low reset.
  in_valid  in  1  one-cycle strobe: new ADC sample on in_sample.
  in_sample  in  14  ADC channel-A sample, signed two's complement.
  coef  in  N_TAPS*COEF_W  packed signed coefficients; tap k at bits [k*COEF_W +: COEF_W].
  in_ready  out  1  high only in IDLE.
  out_valid  out  1  one-cycle strobe: out_sample/out_dac updated.
  out_sample  out  14  filtered sample, signed.
  out_dac  out  12  DAC code, offset binary {~out_sample[13], out_sample[12:2]}.
  overflow  out  1  one-cycle pulse with out_valid when the result exceeded 14-bit range.
  drop_cnt  out  8  count of samples rejected while busy, saturating at 255.

Function
REQ-003 SHALL keep an N_TAPS-deep delay line x[0..N_TAPS-1] of 14-bit samples, x[0] newest.
REQ-004 SHALL run FSM IDLE -> MAC -> ROUND -> OUT -> IDLE.
REQ-005 In IDLE, in_valid high SHALL shift the delay line (x[0] <= in_sample), latch coef, clear the accumulator, enter MAC.
REQ-006 MAC SHALL last exactly N_TAPS cycles, one signed product x[k]*coef[k] per cycle, k = 0 first.
REQ-007 Accumulator SHALL be 14+COEF_W+clog2(N_TAPS) bits signed; no overflow inside MAC.
REQ-008 ROUND SHALL add 2^(FRAC_BITS-1), arithmetic-shift right by FRAC_BITS, then apply REQ-015 range handling.
REQ-009 OUT SHALL register out_sample, out_dac and overflow and assert out_valid for exactly one cycle.
REQ-010 Latency: in_valid accepted at cycle t SHALL give out_valid at cycle t+N_TAPS+2; next sample accepted no earlier than t+N_TAPS+3.
REQ-011 in_valid outside IDLE SHALL be ignored (delay line untouched) and SHALL increment drop_cnt, saturating at 255.
REQ-012 Changes on coef during MAC/ROUND/OUT SHALL NOT affect the result in progress.
REQ-013 out_sample/out_dac SHALL hold their last value between out_valid pulses.

Reset
REQ-014 rst_n low SHALL force at any time, including mid-MAC: state IDLE, delay line and accumulator 0, out_valid 0, overflow 0, out_sample 0, out_dac 12'h800, drop_cnt 0, in_ready 1; an interrupted computation SHALL produce no out_valid.

Configuration
REQ-015 With macro SAMPLE_FIR_SATURATE_EN defined, results above 8191 / below -8192 SHALL clamp to 8191 / -8192 with overflow pulsed; without it, the low 14 bits SHALL be output (wrap) with overflow still pulsed.

Structure
REQ-016 Package sample_fir_pkg SHALL hold SAMPLE_W = 14, DAC_W = 12, sample and DAC code typedefs, FSM state enum, and the offset-binary conversion function.
REQ-017 Multiply-accumulate datapath SHALL be one sub-module, fir_mac (clear, enable, operands, accumulator out); FSM and delay line stay in sample_fir.

Verification
REQ-018 Unity: coef {64,0,0,0}, in_sample 1000 -> out_valid 6 cycles later, out_sample 1000, out_dac 12'h8FA, overflow 0.
REQ-019 Difference: coef {64,-64,0,0}, samples 1000 then 1000 -> outputs 1000 then 0.
REQ-020 Rounding: coef {32,0,0,0}, sample 3 -> 2; after reset, sample -3 -> -1.
REQ-021 Range: coef {127,127,127,127}, four samples of 8191 -> fourth output 8191 with overflow=1 when SAMPLE_FIR_SATURATE_EN defined; wrapped low 14 bits with overflow=1 when undefined.
REQ-022 Busy drop: in_valid at t and t+2 -> one out_valid, drop_cnt=1, delay line holds only the first sample; 300 busy strobes -> drop_cnt=255.
REQ-023 Reset mid-MAC: rst_n low at t+2 after an accept -> no out_valid, out_dac 12'h800, in_ready 1; next sample 500 with unity coef -> output 500.

Source files
------------

// File: rtl/sample_fir_pkg.sv
// sample_fir_pkg: shared widths, types, FSM encoding and DAC conversion for sample_fir.
// Revision 1.0
`default_nettype none

package sample_fir_pkg;

  localparam int SAMPLE_W = 14;
  localparam int DAC_W    = 12;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [DAC_W-1:0]    dac_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Offset binary: flip the sign bit, keep the top DAC_W bits.
  function automatic dac_t to_offset_binary(input sample_t s);
    logic [SAMPLE_W-1:0] w_ob;
    w_ob = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    return dac_t'(w_ob >> (SAMPLE_W - DAC_W));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate, one product per enabled cycle; clear has priority.
// Revision 1.0
`default_nettype none

module fir_mac #(
  parameter int A_W   = 14,
  parameter int B_W   = 8,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  input  logic                    i_enable,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [B_W-1:0]   i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/sample_fir.sv
// sample_fir: sequential N-tap FIR on 14-bit ADC samples with offset-binary DAC output.
// Revision 1.0 -- define SAMPLE_FIR_SATURATE_EN to clamp out-of-range results instead of wrapping.
`default_nettype none

module sample_fir
  import sample_fir_pkg::*;
#(
  parameter int N_TAPS    = 4,
  parameter int COEF_W    = 8,
  parameter int FRAC_BITS = 6
) (
  input  logic                       qzt_clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic [N_TAPS*COEF_W-1:0]   coef,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic signed [SAMPLE_W-1:0] out_sample,
  output logic [DAC_W-1:0]           out_dac,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int ACC_W = SAMPLE_W + COEF_W + $clog2(N_TAPS);
  localparam int TAP_W = $clog2(N_TAPS);

  localparam logic signed [ACC_W:0] C_RND = (ACC_W+1)'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W:0] C_MAX = (ACC_W+1)'(8191);
  localparam logic signed [ACC_W:0] C_MIN = (ACC_W+1)'(-8192);

  state_t                    r_state;
  logic [TAP_W-1:0]          r_tap;
  sample_t                   r_x [N_TAPS];
  logic [N_TAPS*COEF_W-1:0]  r_coef;
  sample_t                   r_out_sample;
  dac_t                      r_out_dac;
  logic                      r_out_valid;
  logic                      r_overflow;
  logic [7:0]                r_drop_cnt;

  logic                      w_accept;
  logic                      w_mac_en;
  sample_t                   w_a;
  logic signed [COEF_W-1:0]  w_b;
  logic signed [ACC_W-1:0]   w_acc;
  logic signed [ACC_W:0]     w_rounded;
  logic signed [ACC_W:0]     w_shifted;
  logic                      w_hi;
  logic                      w_lo;
  sample_t                   w_result;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_mac_en = (r_state == ST_MAC);
  assign w_a      = r_x[r_tap];
  assign w_b      = r_coef[r_tap*COEF_W +: COEF_W];

  fir_mac #(
    .A_W   (SAMPLE_W),
    .B_W   (COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (qzt_clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_enable (w_mac_en),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_acc    (w_acc)
  );

  // Round half up, then floor-shift; the extra bit keeps the rounding add safe.
  assign w_rounded = {w_acc[ACC_W-1], w_acc} + C_RND;
  assign w_shifted = w_rounded >>> FRAC_BITS;
  assign w_hi      = (w_shifted > C_MAX);
  assign w_lo      = (w_shifted < C_MIN);

`ifdef SAMPLE_FIR_SATURATE_EN
  assign w_result = w_hi ? sample_t'(14'sd8191) :
                    w_lo ? sample_t'(-14'sd8192) :
                           sample_t'(w_shifted[SAMPLE_W-1:0]);
`else
  assign w_result = sample_t'(w_shifted[SAMPLE_W-1:0]);
`endif

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tap        <= '0;
      for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
      r_coef       <= '0;
      r_out_sample <= '0;
      r_out_dac    <= 12'h800;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      if (in_valid && (r_state != ST_IDLE) && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x[0] <= in_sample;
            for (int k = 1; k < N_TAPS; k++) r_x[k] <= r_x[k-1];
            r_coef  <= coef;
            r_tap   <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_tap == TAP_W'(N_TAPS - 1)) begin
            r_state <= ST_ROUND;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        ST_ROUND: begin
          r_out_sample <= w_result;
          r_out_dac    <= to_offset_binary(w_result);
          r_overflow   <= w_hi || w_lo;
          r_out_valid  <= 1'b1;
          r_state      <= ST_OUT;
        end
        ST_OUT: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;
  assign out_dac    = r_out_dac;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sample_fir.sv
// tb_sample_fir: randomized self-checking bench for sample_fir against an arithmetic reference model.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sample_fir;

  localparam int N_TAPS = 4;

  logic               qzt_clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [13:0] in_sample = '0;
  logic [31:0]        coef = '0;
  logic               in_ready;
  logic               out_valid;
  logic signed [13:0] out_sample;
  logic [11:0]        out_dac;
  logic               overflow;
  logic [7:0]         drop_cnt;

  int checks = 0;
  int errors = 0;
  int mx [N_TAPS];

  int                 got_lat;
  logic signed [13:0] got_s;
  logic [11:0]        got_d;
  logic               got_o;

  sample_fir #(.N_TAPS(4), .COEF_W(8), .FRAC_BITS(6)) dut (
    .qzt_clk    (qzt_clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .coef       (coef),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_dac    (out_dac),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #10 qzt_clk = ~qzt_clk;

  function automatic logic [31:0] pack4(input int c0, input int c1, input int c2, input int c3);
    return {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N_TAPS; k++) mx[k] = 0;
  endtask

  task automatic model_accept(input int s);
    for (int k = N_TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = s;
  endtask

  // Reference: exact dot product, round half up with floor division by 64, then range rule.
  task automatic model_expect(input logic [31:0] cf, output int res, output int dac, output bit ovf);
    longint acc, num, q;
    acc = 0;
    for (int k = 0; k < N_TAPS; k++) acc += longint'(mx[k]) * longint'($signed(cf[k*8 +: 8]));
    num = acc + 32;
    q = num / 64;
    if ((num % 64 != 0) && (num < 0)) q = q - 1;
    ovf = (q > 8191) || (q < -8192);
`ifdef SAMPLE_FIR_SATURATE_EN
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
`else
    q = q % 16384;
    if (q < 0) q += 16384;
    if (q >= 8192) q -= 16384;
`endif
    res = int'(q);
    dac = (res + 8192) / 4;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge qzt_clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge qzt_clk);
  endtask

  task automatic run_sample(input int s, input logic [31:0] cf);
    got_lat = -1;
    coef = cf;
    in_sample = 14'(s);
    in_valid = 1'b1;
    model_accept(s);
    for (int i = 1; i <= 20; i++) begin
      @(negedge qzt_clk);
      if (i == 1) begin
        in_valid = 1'b0;
        coef = $urandom;
      end
      if (out_valid) begin
        got_lat = i;
        got_s = out_sample;
        got_d = out_dac;
        got_o = overflow;
        break;
      end
    end
    @(negedge qzt_clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge qzt_clk);
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b0 || out_sample !== 14'sd0 ||
        out_dac !== 12'h800 || drop_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got valid=%b ovf=%b s=%0d dac=%h drop=%0d rdy=%b, want 0 0 0 800 0 1",
               out_valid, overflow, out_sample, out_dac, drop_cnt, in_ready);
    end
    rst_n = 1'b1;
    model_clear();
    @(negedge qzt_clk);
  endtask

  task automatic test_unity();
    do_reset();
    run_sample(1000, pack4(64, 0, 0, 0));
    checks++;
    if (got_lat !== N_TAPS + 2) begin
      errors++;
      $display("FAIL unity_latency: got %0d want %0d", got_lat, N_TAPS + 2);
    end
    checks++;
    if (got_s !== 14'sd1000 || got_d !== 12'h8FA || got_o !== 1'b0) begin
      errors++;
      $display("FAIL unity_value: got s=%0d dac=%h ovf=%b want 1000 8fa 0", got_s, got_d, got_o);
    end
    repeat (4) @(negedge qzt_clk);
    checks++;
    if (out_sample !== 14'sd1000 || out_dac !== 12'h8FA || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL unity_hold: got s=%0d dac=%h valid=%b want 1000 8fa 0", out_sample, out_dac, out_valid);
    end
  endtask

  task automatic test_difference();
    do_reset();
    run_sample(1000, pack4(64, -64, 0, 0));
    checks++;
    if (got_s !== 14'sd1000) begin
      errors++;
      $display("FAIL diff_first: got %0d want 1000", got_s);
    end
    run_sample(1000, pack4(64, -64, 0, 0));
    checks++;
    if (got_s !== 14'sd0 || got_d !== 12'h800) begin
      errors++;
      $display("FAIL diff_second: got s=%0d dac=%h want 0 800", got_s, got_d);
    end
  endtask

  task automatic test_rounding();
    do_reset();
    run_sample(3, pack4(32, 0, 0, 0));
    checks++;
    if (got_s !== 14'sd2) begin
      errors++;
      $display("FAIL round_pos: got %0d want 2", got_s);
    end
    do_reset();
    run_sample(-3, pack4(32, 0, 0, 0));
    checks++;
    if (got_s !== -14'sd1) begin
      errors++;
      $display("FAIL round_neg: got %0d want -1", got_s);
    end
  endtask

  task automatic test_range();
    int exp_s, exp_d;
    bit exp_o;
    int want4;
`ifdef SAMPLE_FIR_SATURATE_EN
    want4 = 8191;
`else
    want4 = -520;
`endif
    do_reset();
    for (int n = 0; n < 4; n++) begin
      run_sample(8191, pack4(127, 127, 127, 127));
      model_expect(pack4(127, 127, 127, 127), exp_s, exp_d, exp_o);
      checks++;
      if (got_s !== 14'(exp_s) || got_o !== 1'b1 || got_d !== 12'(exp_d)) begin
        errors++;
        $display("FAIL range_%0d: got s=%0d dac=%h ovf=%b want %0d %h 1", n, got_s, got_d, got_o, exp_s, exp_d[11:0]);
      end
    end
    checks++;
    if (got_s !== 14'(want4)) begin
      errors++;
      $display("FAIL range_fourth: got %0d want %0d", got_s, want4);
    end
  endtask

  task automatic test_busy_drop();
    int pulses;
    logic signed [13:0] first_s;
    do_reset();
    first_s = '0;
    pulses = 0;
    coef = pack4(64, 0, 0, 0);
    in_sample = 14'sd1234;
    in_valid = 1'b1;
    model_accept(1234);
    @(negedge qzt_clk);
    in_valid = 1'b0;
    @(negedge qzt_clk);
    in_valid = 1'b1;
    in_sample = 14'sd777;
    @(negedge qzt_clk);
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        pulses++;
        first_s = out_sample;
      end
      @(negedge qzt_clk);
    end
    checks++;
    if (pulses != 1 || first_s !== 14'sd1234) begin
      errors++;
      $display("FAIL busy_one_output: got pulses=%0d s=%0d want 1 1234", pulses, first_s);
    end
    checks++;
    if (drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL busy_drop_cnt: got %0d want 1", drop_cnt);
    end
    run_sample(555, pack4(0, 64, 0, 0));
    checks++;
    if (got_s !== 14'sd1234) begin
      errors++;
      $display("FAIL busy_delay_line: got %0d want 1234", got_s);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      in_sample = 14'($urandom);
      @(negedge qzt_clk);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge qzt_clk);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL busy_saturate: got %0d want 255", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_mac();
    int pulses;
    do_reset();
    pulses = 0;
    coef = pack4(64, 0, 0, 0);
    in_sample = 14'sd321;
    in_valid = 1'b1;
    @(negedge qzt_clk);
    in_valid = 1'b0;
    @(negedge qzt_clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_dac !== 12'h800 || out_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midmac_reset: got rdy=%b dac=%h valid=%b drop=%0d want 1 800 0 0",
               in_ready, out_dac, out_valid, drop_cnt);
    end
    @(negedge qzt_clk);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 12; i++) begin
      if (out_valid) pulses++;
      @(negedge qzt_clk);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midmac_no_output: got %0d pulses want 0", pulses);
    end
    run_sample(500, pack4(64, 0, 0, 0));
    checks++;
    if (got_s !== 14'sd500 || got_lat !== N_TAPS + 2) begin
      errors++;
      $display("FAIL midmac_recover: got s=%0d lat=%0d want 500 %0d", got_s, got_lat, N_TAPS + 2);
    end
  endtask

  task automatic test_random();
    int exp_s, exp_d, s;
    bit exp_o;
    logic [31:0] cf;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      cf = $urandom;
      s = int'($urandom_range(0, 16383)) - 8192;
      run_sample(s, cf);
      model_expect(cf, exp_s, exp_d, exp_o);
      checks++;
      if (got_lat !== N_TAPS + 2 || got_s !== 14'(exp_s) || got_d !== 12'(exp_d) || got_o !== exp_o) begin
        errors++;
        $display("FAIL random_%0d: got lat=%0d s=%0d dac=%h ovf=%b want %0d %0d %h %b",
                 n, got_lat, got_s, got_d, got_o, N_TAPS + 2, exp_s, exp_d[11:0], exp_o);
      end
      checks++;
      if (out_sample !== 14'(exp_s)) begin
        errors++;
        $display("FAIL random_hold_%0d: got %0d want %0d", n, out_sample, exp_s);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge qzt_clk);
    test_reset();
    test_unity();
    test_difference();
    test_rounding();
    test_range();
    test_busy_drop();
    test_reset_mid_mac();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
